mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit in the execute stage, directly downstream of register_file.

---
 rtl/mult_div_unit_pkg.sv | 28 ++
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mult_div_unit.sv | 145 ++++++++++++++
 tb/tb_mult_div_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encodings and small op-decode helpers.
package mult_div_unit_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ITER = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   function automatic logic op_is_signed(input op_t op);
      return (op == MDU_MULT) || (op == MDU_DIV);
   endfunction

   function automatic logic op_is_div(input op_t op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute-stage control and the
// multiply/divide unit. master = pipeline side, slave = the unit.
interface mult_div_unit_if
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) ();

   logic             start;
   op_t              op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, operand_a, operand_b, cancel,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, operand_a, operand_b, cancel,
      output busy, done, div_by_zero, hi, lo
   );

endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, signs applied in FIX.
// Operand conditioning (abs) happens in the start cycle, so the LOAD cycle
// already performs the first iteration step; LOAD plus ITER together make
// exactly WIDTH steps and done lands WIDTH+2 cycles after start.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   mult_div_unit_if.slave bus
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic               div_reg, b_zero_reg, neg_q_reg, neg_r_reg, dbz_reg;
   logic [WIDTH-1:0]   a_raw_reg, a_mag_reg, b_mag_reg, hi_reg, lo_reg;
   logic [2*WIDTH-1:0] acc_reg;

   logic               accept, load_en, in_signed, in_div, sign_a, sign_b;
   logic [WIDTH-1:0]   a_mag_in, b_mag_in;

   // cancel in the same cycle as start suppresses the start
   assign accept    = bus.start && !bus.cancel;
   assign load_en   = accept && ((state_reg == S_IDLE) || (state_reg == S_DONE));
   assign in_signed = op_is_signed(bus.op);
   assign in_div    = op_is_div(bus.op);
   assign sign_a    = in_signed && bus.operand_a[WIDTH-1];
   assign sign_b    = in_signed && bus.operand_b[WIDTH-1];
   assign a_mag_in  = sign_a ? -bus.operand_a : bus.operand_a;
   assign b_mag_in  = sign_b ? -bus.operand_b : bus.operand_b;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= S_IDLE;
      else        state_reg <= state_next;
   end

   // next-state logic; cancel aborts any in-flight state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (accept) state_next = S_LOAD;
         S_LOAD: state_next = bus.cancel ? S_IDLE : S_ITER;
         S_ITER: if (bus.cancel)               state_next = S_IDLE;
                 else if (cnt_reg == CNT_LAST) state_next = S_FIX;
         S_FIX:  state_next = bus.cancel ? S_IDLE : S_DONE;
         S_DONE: state_next = accept ? S_LOAD : S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // one iteration step: add-shift for multiply, restoring subtract for divide.
   // The accumulator holds {partial product high, multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] step_acc;
   logic               unused_ok;

   always_comb begin
      mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                + (acc_reg[0] ? {1'b0, a_mag_reg} : {(WIDTH+1){1'b0}});
      div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
      div_diff  = div_shift - {1'b0, b_mag_reg};
      div_ge    = (div_shift >= {1'b0, b_mag_reg});
      div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_acc  = div_reg ? {div_rem, acc_reg[WIDTH-2:0], div_ge}
                          : {mul_sum, acc_reg[WIDTH-1:1]};
   end

   // a kept remainder is below the divisor, so the difference MSB is always 0
   assign unused_ok = div_diff[WIDTH];

   // sign fix-up of the magnitude result; divide by zero bypasses the datapath
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   always_comb begin
      prod_fix = neg_q_reg ? -acc_reg : acc_reg;
      fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo   = prod_fix[WIDTH-1:0];
      if (div_reg) begin
         if (b_zero_reg) begin
            fix_hi = a_raw_reg;
            fix_lo = {WIDTH{1'b1}};
         end else begin
            fix_lo = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
            fix_hi = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
         end
      end
   end

   // operand capture, iteration and result registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg    <= '0;
         div_reg    <= 1'b0;
         b_zero_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dbz_reg    <= 1'b0;
         a_raw_reg  <= '0;
         a_mag_reg  <= '0;
         b_mag_reg  <= '0;
         acc_reg    <= '0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         if (load_en) begin
            div_reg    <= in_div;
            b_zero_reg <= (bus.operand_b == '0);
            neg_q_reg  <= sign_a ^ sign_b;
            neg_r_reg  <= sign_a;
            a_raw_reg  <= bus.operand_a;
            a_mag_reg  <= a_mag_in;
            b_mag_reg  <= b_mag_in;
            acc_reg    <= {{WIDTH{1'b0}}, (in_div ? a_mag_in : b_mag_in)};
            cnt_reg    <= '0;
         end else if ((state_reg == S_LOAD) || (state_reg == S_ITER)) begin
            acc_reg <= step_acc;
            cnt_reg <= cnt_reg + CNT_W'(1);
         end
         dbz_reg <= 1'b0;
         if ((state_reg == S_FIX) && !bus.cancel) begin
            hi_reg  <= fix_hi;
            lo_reg  <= fix_lo;
            dbz_reg <= div_reg && b_zero_reg;
         end
      end
   end

   assign bus.busy        = (state_reg == S_LOAD) || (state_reg == S_ITER) || (state_reg == S_FIX);
   assign bus.done        = (state_reg == S_DONE);
   assign bus.div_by_zero = dbz_reg;
   assign bus.hi          = hi_reg;
   assign bus.lo          = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: latency, signed/unsigned multiply
// and divide, divide by zero, overflow, start filtering, back-to-back,
// cancel and mid-operation reset.
module tb_mult_div_unit;
   import mult_div_unit_pkg::*;

   localparam int WIDTH = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_compared   = 0;
   int   n_mismatched = 0;

   mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

   mult_div_unit #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // start is high during cycle 0; returns #1 into cycle 1 with start low
   task automatic issue(input op_t op, input logic [31:0] a, input logic [31:0] b);
      @(posedge clk);
      #1;
      bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b;
      next_cycle();
      bus.start = 1'b0;
   endtask

   // bounded wait for done starting in cycle cyc0; ends at the negedge of the done cycle
   task automatic wait_done(input int cyc0, output int done_cyc, output int busy_cnt);
      int cyc = cyc0;
      done_cyc = -1;
      busy_cnt = 0;
      while (cyc < cyc0 + 80) begin
         @(negedge clk);
         if (bus.done) begin
            done_cyc = cyc;
            break;
         end
         if (bus.busy) busy_cnt++;
         next_cycle();
         cyc++;
      end
   endtask

   task automatic show(input string tag, input int dc);
      $display("%s: op=%s a=%h b=%h -> hi=%h lo=%h dbz=%b done_cycle=%0d",
               tag, bus.op.name(), bus.operand_a, bus.operand_b, bus.hi, bus.lo, bus.div_by_zero, dc);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) next_cycle();
      @(negedge clk);
      n_compared++; if (bus.busy !== 1'b0)        begin n_mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_compared++; if (bus.done !== 1'b0)        begin n_mismatched++; $display("FAIL reset_done: got %b want 0", bus.done); end
      n_compared++; if (bus.div_by_zero !== 1'b0) begin n_mismatched++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
      n_compared++; if (bus.hi !== 32'h0)         begin n_mismatched++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
      n_compared++; if (bus.lo !== 32'h0)         begin n_mismatched++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
      $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
      rst_n = 1'b1;
   endtask

   task automatic test_multu_latency();
      int dc, bc;
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(1, dc, bc);
      show("multu", dc);
      n_compared++; if (dc !== 34)                begin n_mismatched++; $display("FAIL multu_done_cycle: got %0d want 34", dc); end
      n_compared++; if (bc !== 33)                begin n_mismatched++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
      n_compared++; if (bus.busy !== 1'b0)        begin n_mismatched++; $display("FAIL multu_busy_at_done: got %b want 0", bus.busy); end
      n_compared++; if (bus.hi !== 32'hFFFF_FFFE) begin n_mismatched++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
      n_compared++; if (bus.lo !== 32'h0000_0001) begin n_mismatched++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
      n_compared++; if (bus.div_by_zero !== 1'b0) begin n_mismatched++; $display("FAIL multu_dbz: got %b want 0", bus.div_by_zero); end
      next_cycle();
      @(negedge clk);
      n_compared++; if (bus.done !== 1'b0)        begin n_mismatched++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
      n_compared++; if (bus.lo !== 32'h0000_0001) begin n_mismatched++; $display("FAIL multu_lo_hold: got %h want 00000001", bus.lo); end
   endtask

   task automatic test_mult_signed();
      int dc, bc;
      issue(MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
      wait_done(1, dc, bc);
      show("mult", dc);
      n_compared++; if (bus.hi !== 32'hFFFF_FFFF) begin n_mismatched++; $display("FAIL mult_neg_hi: got %h want ffffffff", bus.hi); end
      n_compared++; if (bus.lo !== 32'hFFFF_FFF1) begin n_mismatched++; $display("FAIL mult_neg_lo: got %h want fffffff1", bus.lo); end
      issue(MDU_MULT, 32'h8000_0000, 32'h8000_0000);
      wait_done(1, dc, bc);
      show("mult", dc);
      n_compared++; if (bus.hi !== 32'h4000_0000) begin n_mismatched++; $display("FAIL mult_min_hi: got %h want 40000000", bus.hi); end
      n_compared++; if (bus.lo !== 32'h0000_0000) begin n_mismatched++; $display("FAIL mult_min_lo: got %h want 00000000", bus.lo); end
   endtask

   task automatic test_div();
      int dc, bc;
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      wait_done(1, dc, bc);
      show("div", dc);
      n_compared++; if (dc !== 34)                begin n_mismatched++; $display("FAIL div_done_cycle: got %0d want 34", dc); end
      n_compared++; if (bus.lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL div_negdvd_lo: got %h want fffffffd", bus.lo); end
      n_compared++; if (bus.hi !== 32'hFFFF_FFFF) begin n_mismatched++; $display("FAIL div_negdvd_hi: got %h want ffffffff", bus.hi); end
      issue(MDU_DIVU, 32'h0000_0007, 32'h0000_0002);
      wait_done(1, dc, bc);
      show("divu", dc);
      n_compared++; if (bus.lo !== 32'h0000_0003) begin n_mismatched++; $display("FAIL divu_lo: got %h want 00000003", bus.lo); end
      n_compared++; if (bus.hi !== 32'h0000_0001) begin n_mismatched++; $display("FAIL divu_hi: got %h want 00000001", bus.hi); end
      issue(MDU_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
      wait_done(1, dc, bc);
      show("div", dc);
      n_compared++; if (bus.lo !== 32'hFFFF_FFFD) begin n_mismatched++; $display("FAIL div_negdvs_lo: got %h want fffffffd", bus.lo); end
      n_compared++; if (bus.hi !== 32'h0000_0001) begin n_mismatched++; $display("FAIL div_negdvs_hi: got %h want 00000001", bus.hi); end
   endtask

   task automatic test_div_special();
      int dc, bc;
      issue(MDU_DIV, 32'h0000_1234, 32'h0000_0000);
      wait_done(1, dc, bc);
      show("div0", dc);
      n_compared++; if (dc !== 34)                begin n_mismatched++; $display("FAIL dbz_done_cycle: got %0d want 34", dc); end
      n_compared++; if (bus.lo !== 32'hFFFF_FFFF) begin n_mismatched++; $display("FAIL dbz_lo: got %h want ffffffff", bus.lo); end
      n_compared++; if (bus.hi !== 32'h0000_1234) begin n_mismatched++; $display("FAIL dbz_hi: got %h want 00001234", bus.hi); end
      n_compared++; if (bus.div_by_zero !== 1'b1) begin n_mismatched++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
      next_cycle();
      @(negedge clk);
      n_compared++; if (bus.div_by_zero !== 1'b0) begin n_mismatched++; $display("FAIL dbz_clear: got %b want 0", bus.div_by_zero); end
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(1, dc, bc);
      show("div_ovf", dc);
      n_compared++; if (bus.lo !== 32'h8000_0000) begin n_mismatched++; $display("FAIL ovf_lo: got %h want 80000000", bus.lo); end
      n_compared++; if (bus.hi !== 32'h0000_0000) begin n_mismatched++; $display("FAIL ovf_hi: got %h want 00000000", bus.hi); end
      n_compared++; if (bus.div_by_zero !== 1'b0) begin n_mismatched++; $display("FAIL ovf_dbz: got %b want 0", bus.div_by_zero); end
   endtask

   task automatic test_back_to_back();
      int dc, bc;
      // DIVU 100/7 captured; later operand/op changes and a start while busy are ignored
      @(posedge clk);
      #1;
      bus.start = 1'b1; bus.op = MDU_DIVU; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
      next_cycle();
      bus.start = 1'b0; bus.op = MDU_MULT; bus.operand_a = 32'd55; bus.operand_b = 32'd3;
      repeat (4) next_cycle();
      bus.start = 1'b1;
      next_cycle();
      bus.start = 1'b0;
      wait_done(6, dc, bc);
      $display("ignored-start: hi=%h lo=%h done_cycle=%0d", bus.hi, bus.lo, dc);
      n_compared++; if (dc !== 34)                begin n_mismatched++; $display("FAIL ignore_done_cycle: got %0d want 34", dc); end
      n_compared++; if (bus.lo !== 32'd14)        begin n_mismatched++; $display("FAIL ignore_lo: got %h want 0000000e", bus.lo); end
      n_compared++; if (bus.hi !== 32'd2)         begin n_mismatched++; $display("FAIL ignore_hi: got %h want 00000002", bus.hi); end
      // start in the done cycle
      bus.start = 1'b1; bus.op = MDU_MULTU; bus.operand_a = 32'd6; bus.operand_b = 32'd7;
      next_cycle();
      bus.start = 1'b0;
      wait_done(1, dc, bc);
      show("b2b", dc);
      n_compared++; if (dc !== 34)                begin n_mismatched++; $display("FAIL b2b_done_cycle: got %0d want 34", dc); end
      n_compared++; if (bus.lo !== 32'd42)        begin n_mismatched++; $display("FAIL b2b_lo: got %h want 0000002a", bus.lo); end
      n_compared++; if (bus.hi !== 32'd0)         begin n_mismatched++; $display("FAIL b2b_hi: got %h want 00000000", bus.hi); end
      next_cycle();
      @(negedge clk);
      n_compared++; if (bus.busy !== 1'b0)        begin n_mismatched++; $display("FAIL b2b_no_queue: got busy %b want 0", bus.busy); end
   endtask

   task automatic test_cancel();
      int dc, bc, n_done;
      issue(MDU_MULTU, 32'd3, 32'd4);
      wait_done(1, dc, bc);
      show("pre-cancel", dc);
      n_compared++; if (bus.lo !== 32'd12)        begin n_mismatched++; $display("FAIL precancel_lo: got %h want 0000000c", bus.lo); end
      issue(MDU_MULTU, 32'd1000, 32'd1000);
      repeat (9) next_cycle();
      bus.cancel = 1'b1;
      next_cycle();
      bus.cancel = 1'b0;
      @(negedge clk);
      $display("cancel: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
      n_compared++; if (bus.busy !== 1'b0)        begin n_mismatched++; $display("FAIL cancel_busy: got %b want 0", bus.busy); end
      n_compared++; if (bus.lo !== 32'd12)        begin n_mismatched++; $display("FAIL cancel_lo_keep: got %h want 0000000c", bus.lo); end
      n_compared++; if (bus.hi !== 32'd0)         begin n_mismatched++; $display("FAIL cancel_hi_keep: got %h want 00000000", bus.hi); end
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         @(negedge clk);
         if (bus.done) n_done++;
      end
      n_compared++; if (n_done !== 0)             begin n_mismatched++; $display("FAIL cancel_no_done: got %0d pulses want 0", n_done); end
      // cancel together with start in IDLE: nothing starts
      @(posedge clk);
      #1;
      bus.start = 1'b1; bus.cancel = 1'b1; bus.op = MDU_MULTU; bus.operand_a = 32'd5; bus.operand_b = 32'd5;
      next_cycle();
      bus.start = 1'b0; bus.cancel = 1'b0;
      @(negedge clk);
      $display("cancel+start: busy=%b", bus.busy);
      n_compared++; if (bus.busy !== 1'b0)        begin n_mismatched++; $display("FAIL cancel_start_busy: got %b want 0", bus.busy); end
      n_done = 0;
      for (int i = 0; i < 40; i++) begin
         next_cycle();
         @(negedge clk);
         if (bus.done) n_done++;
      end
      n_compared++; if (n_done !== 0)             begin n_mismatched++; $display("FAIL cancel_start_no_done: got %0d pulses want 0", n_done); end
      n_compared++; if (bus.lo !== 32'd12)        begin n_mismatched++; $display("FAIL cancel_start_lo: got %h want 0000000c", bus.lo); end
   endtask

   task automatic test_reset_mid();
      int dc, bc;
      issue(MDU_DIVU, 32'd1000, 32'd3);
      repeat (19) next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      $display("mid-reset: busy=%b done=%b hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);
      n_compared++; if (bus.hi !== 32'd0)         begin n_mismatched++; $display("FAIL midrst_hi: got %h want 0", bus.hi); end
      n_compared++; if (bus.lo !== 32'd0)         begin n_mismatched++; $display("FAIL midrst_lo: got %h want 0", bus.lo); end
      n_compared++; if (bus.busy !== 1'b0)        begin n_mismatched++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
      n_compared++; if (bus.done !== 1'b0)        begin n_mismatched++; $display("FAIL midrst_done: got %b want 0", bus.done); end
      issue(MDU_DIVU, 32'd7, 32'd2);
      wait_done(1, dc, bc);
      show("post-reset", dc);
      n_compared++; if (dc !== 34)                begin n_mismatched++; $display("FAIL postrst_done_cycle: got %0d want 34", dc); end
      n_compared++; if (bus.lo !== 32'd3)         begin n_mismatched++; $display("FAIL postrst_lo: got %h want 00000003", bus.lo); end
      n_compared++; if (bus.hi !== 32'd1)         begin n_mismatched++; $display("FAIL postrst_hi: got %h want 00000001", bus.hi); end
   endtask

   // Global time limit in case a wait misbehaves
   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Test sequence
   initial begin
      bus.start     = 1'b0;
      bus.cancel    = 1'b0;
      bus.op        = MDU_MULT;
      bus.operand_a = '0;
      bus.operand_b = '0;
      test_reset();
      test_multu_latency();
      test_mult_signed();
      test_div();
      test_div_special();
      test_back_to_back();
      test_cancel();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
